// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results pass straight through,
// load results wait in a small FIFO; optional bypass lookup via WB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              write,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_rd,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mem_q [DEPTH];
  ent_t              mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic issue;
  ent_t win;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign ld_ready = !full;

  assign write     = write_q;
  assign writeReg  = wreg_q;
  assign writeData = wdata_q;
  assign pending   = !empty || write_q;

  // Pick the winner for this cycle and compute next FIFO/output state.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;
    alu_ready = 1'b0;
    deq      = 1'b0;
    issue    = 1'b0;
    win      = '0;
    enq      = ld_valid && !full;

    if (full) begin
      deq   = 1'b1;
      issue = 1'b1;
      win   = mem_q[rd_ptr_q];
    end else if (alu_valid) begin
      alu_ready = 1'b1;
      issue     = 1'b1;
      win       = '{rd: alu_rd, data: alu_data};
    end else if (!empty) begin
      deq   = 1'b1;
      issue = 1'b1;
      win   = mem_q[rd_ptr_q];
    end

    // x0 writes still burn the slot but leave the port idle.
    if (issue && (win.rd != '0)) begin
      write_d = 1'b1;
      wreg_d  = win.rd;
      wdata_d = win.data;
    end

    if (enq) begin
      mem_d[wr_ptr_q] = '{rd: ld_rd, data: ld_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; FIFO storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      mem_q    <= mem_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Newest pending value for byp_rd: output register first, then
  // FIFO oldest to youngest so the youngest match overrides.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    if (byp_rd != '0) begin
      if (write_q && (wreg_q == byp_rd)) begin
        byp_hit  = 1'b1;
        byp_data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if ((CNT_W'(i) < cnt_q) && (mem_q[idx].rd == byp_rd)) begin
          byp_hit  = 1'b1;
          byp_data = mem_q[idx].data;
        end
      end
    end
  end
`endif

endmodule
